if_stage: RTL

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the decode stage. Holds the program counter, drives the instruction-memory read port and owns the IF/ID pipeline register that supplies decode with `IFID_instruction` and `IFID_NPC`. It applies taken-branch and jump redirects, load-use stalls, memory wait states and flushes.

---
 rtl/if_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read port
// and registers the fetched word plus its PC+4 into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] IFID_instruction,
  output logic [31:0] IFID_NPC,
  output logic        IFID_valid
);

  typedef enum logic [2:0] {
    ACT_BRANCH,
    ACT_STALL,
    ACT_JUMP,
    ACT_FLUSH,
    ACT_FETCH,
    ACT_WAIT
  } fetch_act_e;

  fetch_act_e  act;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] seq_pc;

  assign seq_pc = pc_q + 32'd4;

  // Priority of the redirect/hold sources; the first match wins.
  always_comb begin
    act = ACT_WAIT;
    if (branch_taken)    act = ACT_BRANCH;
    else if (stall)      act = ACT_STALL;
    else if (jump)       act = ACT_JUMP;
    else if (flush)      act = ACT_FLUSH;
    else if (imem_ready) act = ACT_FETCH;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = NOP;
    npc_d   = '0;
    valid_d = 1'b0;
    unique case (act)
      ACT_BRANCH: pc_d = {branch_target[31:2], 2'b00};
      ACT_STALL: begin
        // A stall keeps ID's instruction unless it is also being squashed.
        if (!flush) begin
          instr_d = instr_q;
          npc_d   = npc_q;
          valid_d = valid_q;
        end
      end
      ACT_JUMP:  pc_d = {jump_target[31:2], 2'b00};
      ACT_FLUSH: if (imem_ready) pc_d = seq_pc;
      ACT_FETCH: begin
        pc_d    = seq_pc;
        instr_d = imem_rdata;
        npc_d   = seq_pc;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req         = ~stall | branch_taken;
  assign imem_addr        = pc_q;
  assign pc               = pc_q;
  assign IFID_instruction = instr_q;
  assign IFID_NPC         = npc_q;
  assign IFID_valid       = valid_q;

endmodule
